instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the instruction queue depth (power of two, 2..64).
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles to wait for ctl_done before aborting.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 The block SHALL have ports host_valid (input, 1 bit), host_instr (input, 32 bits) and host_ready (output, 1 bit), meaning the host push handshake.
REQ-006 The block SHALL have ports go (input, 1 bit, one-cycle pulse that sets running) and flush (input, 1 bit, clears the queue).
REQ-007 The block SHALL have ports ctl_start (output, 1 bit, one-cycle issue pulse) and ctl_instr (output, 32 bits, instruction to the array controller).
REQ-008 The block SHALL have port ctl_done, input, 1 bit, meaning a one-cycle pulse from the array controller when the current instruction completes.
REQ-009 The block SHALL have status outputs busy (1 bit), running (1 bit), level ($clog2(DEPTH)+1 bits), issued_cnt (16 bits) and err_timeout (1 bit, sticky).

Function
REQ-010 The queue SHALL be FIFO-ordered; a push occurs when host_valid && host_ready; host_ready = (level < DEPTH), with no full-bypass.
REQ-011 When the queue is full, host_valid SHALL be ignored with no data loss or corruption (the host holds).
REQ-012 Pointers SHALL wrap modulo DEPTH; level SHALL change by +1, -1 or 0 (push and pop in the same cycle).
REQ-013 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-014 IDLE -> ISSUE SHALL occur when running && level != 0 && !flush.
REQ-015 In ISSUE, if head[31:28] == 4'hF (HALT), the block SHALL pop it, clear running, assert no ctl_start and return to IDLE.
REQ-016 In ISSUE with a non-HALT head, the block SHALL assert ctl_start for exactly one cycle, drive ctl_instr = head, pop, increment issued_cnt (wrapping at 16 bits) and go to WAIT.
REQ-017 ctl_instr SHALL hold its last issued value until the next issue.
REQ-018 In WAIT, ctl_done SHALL return the FSM to IDLE the following cycle; ctl_done outside WAIT SHALL be ignored.
REQ-019 The WAIT cycle counter SHALL start at 0 on entry; on reaching TIMEOUT-1 without ctl_done, the block SHALL set err_timeout, clear running and go to IDLE.
REQ-020 Latency SHALL be: push at edge t, ctl_start high in cycle t+2 (when running and the queue was empty); back-to-back issues SHALL be no closer than ctl_done + 2 cycles.
REQ-021 flush SHALL empty the queue (level = 0) in any state; in WAIT the FSM SHALL still wait for ctl_done or timeout; flush SHALL win over a simultaneous push.
REQ-022 go while running SHALL have no effect; go in the same cycle as a HALT pop SHALL leave running = 0.
REQ-023 busy SHALL equal (state != IDLE) || (running && level != 0).

Reset
REQ-024 On reset, the block SHALL set state = IDLE, pointers = 0, level = 0, running = 0, ctl_start = 0, ctl_instr = 0, issued_cnt = 0, err_timeout = 0 and host_ready = 1 on the next cycle.
REQ-025 Reset during WAIT SHALL abandon the instruction without a further ctl_start; a ctl_done arriving after reset SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state enumeration, the HALT opcode 4'hF, the opcode field position [31:28] and the instruction width 32.
REQ-027 The queue SHALL be a sub-module named instr_fifo (storage, pointers, level); the FSM, watchdog and counters SHALL live in instr_sequencer.

Verification
REQ-028 Reset, push 0x1000_0001, 0x1000_0002 and 0x1000_0003, pulse go, return ctl_done 5 cycles after each start -> three ctl_start pulses in order, issued_cnt = 3, level = 0, busy = 0.
REQ-029 Push 8 words with DEPTH = 8 and running = 0 -> host_ready = 0 and level = 8; a 9th host_valid is held; after go and the first issue, the 9th is accepted and all 9 issue in order.
REQ-030 Queue 0x1000_0001, 0xF000_0000, 0x1000_0002, pulse go -> one ctl_start (0x1000_0001), running = 0, level = 1; a second go issues 0x1000_0002.
REQ-031 Issue one instruction and never assert ctl_done -> err_timeout = 1 exactly TIMEOUT cycles after WAIT entry, FSM in IDLE, running = 0.
REQ-032 In WAIT with level = 4, pulse flush together with host_valid -> level = 0 with no push; ctl_done -> IDLE with no further ctl_start.
REQ-033 Assert reset in WAIT, then pulse ctl_done -> all outputs at reset values and no ctl_start.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states and the
// instruction word layout (opcode field and the HALT opcode).
package instr_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;

    localparam logic [OP_MSB-OP_LSB:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    // True when the instruction's opcode field marks it as a HALT marker.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[OP_MSB:OP_LSB] == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction queue: DEPTH-entry FIFO with wrapping pointers and a level count.
// Push is refused when full (the host holds its word); flush empties the
// queue and takes priority over any push or pop in the same cycle.
module instr_fifo
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [INSTR_W-1:0]       push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [INSTR_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic               do_push;
    logic               do_pop;

    assign ready = (level_q < FULL_LEVEL);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and level; flush overrides everything.
    always_comb begin
        do_push  = push && ready && !flush;
        do_pop   = pop && (level_q != '0) && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Register the queue; storage contents need no reset since level gates use.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host instructions and issues them one at a
// time to the array controller, waiting for ctl_done (or a watchdog timeout)
// between issues. A HALT-opcode word stops the run without being issued.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [INSTR_W-1:0]       host_instr,
    output logic                     host_ready,
    input  logic                     go,
    input  logic                     flush,
    output logic                     ctl_start,
    output logic [INSTR_W-1:0]       ctl_instr,
    input  logic                     ctl_done,
    output logic                     busy,
    output logic                     running,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              issued_cnt,
    output logic                     err_timeout
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [15:0]   ISSUE_ONE = 16'd1;

    seq_state_e         state_q, state_d;
    logic               running_q, running_d;
    logic               ctl_start_q, ctl_start_d;
    logic [INSTR_W-1:0] ctl_instr_q, ctl_instr_d;
    logic [15:0]        issued_cnt_q, issued_cnt_d;
    logic               err_timeout_q, err_timeout_d;
    logic [CW-1:0]      wait_cnt_q, wait_cnt_d;

    logic               fifo_pop;
    logic [INSTR_W-1:0] fifo_head;
    logic [LW-1:0]      fifo_level;
    logic               fifo_ready;
    logic               queue_empty;

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_valid),
        .push_data (host_instr),
        .pop       (fifo_pop),
        .flush     (flush),
        .head      (fifo_head),
        .level     (fifo_level),
        .ready     (fifo_ready)
    );

    assign queue_empty = (fifo_level == '0);

    assign host_ready  = fifo_ready;
    assign level       = fifo_level;
    assign ctl_start   = ctl_start_q;
    assign ctl_instr   = ctl_instr_q;
    assign running     = running_q;
    assign issued_cnt  = issued_cnt_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != ST_IDLE) || (running_q && !queue_empty);

    // Next-state logic for the issue FSM, run flag, watchdog and counters.
    always_comb begin
        state_d       = state_q;
        running_d     = running_q;
        ctl_start_d   = 1'b0;
        ctl_instr_d   = ctl_instr_q;
        issued_cnt_d  = issued_cnt_q;
        err_timeout_d = err_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        fifo_pop      = 1'b0;

        // go only starts a stopped sequencer; later HALT/timeout may override.
        if (go && !running_q) begin
            running_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (running_q && !queue_empty && !flush) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush || queue_empty) begin
                    // The head vanished under a flush; nothing to issue.
                    state_d = ST_IDLE;
                end else if (is_halt(fifo_head)) begin
                    fifo_pop  = 1'b1;
                    running_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    fifo_pop     = 1'b1;
                    ctl_start_d  = 1'b1;
                    ctl_instr_d  = fifo_head;
                    issued_cnt_d = issued_cnt_q + ISSUE_ONE;
                    wait_cnt_d   = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ctl_done) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    running_d     = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Single register bank for the FSM and all of its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            running_q     <= 1'b0;
            ctl_start_q   <= 1'b0;
            ctl_instr_q   <= '0;
            issued_cnt_q  <= '0;
            err_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            running_q     <= running_d;
            ctl_start_q   <= ctl_start_d;
            ctl_instr_q   <= ctl_instr_d;
            issued_cnt_q  <= issued_cnt_d;
            err_timeout_q <= err_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

endmodule
